// File: rtl/mem_read_arbiter.sv
// Two-master AXI4 read-channel arbiter (port 0 = I-cache, port 1 = D-cache), one burst in flight.
// Optional rid-vs-grant check producing a sticky arb_err is enabled by defining ARB_ID_CHECK_EN.
module mem_read_arbiter #(
    parameter int ID_WIDTH   = 13,
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  m0_arvalid,
    output logic                  m0_arready,
    input  logic [ADDR_WIDTH-1:0] m0_araddr,
    input  logic [7:0]            m0_arlen,
    output logic                  m0_rvalid,
    input  logic                  m0_rready,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    output logic                  m0_rlast,

    input  logic                  m1_arvalid,
    output logic                  m1_arready,
    input  logic [ADDR_WIDTH-1:0] m1_araddr,
    input  logic [7:0]            m1_arlen,
    output logic                  m1_rvalid,
    input  logic                  m1_rready,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic                  m1_rlast,

    output logic                  axi_arvalid,
    input  logic                  axi_arready,
    output logic [ADDR_WIDTH-1:0] axi_araddr,
    output logic [7:0]            axi_arlen,
    output logic [ID_WIDTH-1:0]   axi_arid,
    input  logic                  axi_rvalid,
    output logic                  axi_rready,
    input  logic [DATA_WIDTH-1:0] axi_rdata,
    input  logic                  axi_rlast,
    input  logic [ID_WIDTH-1:0]   axi_rid
`ifdef ARB_ID_CHECK_EN
    ,
    output logic                  arb_err
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   grant_q, grant_d;
    logic   last_q,  last_d;

    logic [1:0]            req_arvalid;
    logic [1:0]            req_rready;
    logic [ADDR_WIDTH-1:0] req_araddr [2];
    logic [7:0]            req_arlen  [2];

    logic [1:0]            resp_arready;
    logic [1:0]            resp_rvalid;
    logic [1:0]            resp_rlast;
    logic [DATA_WIDTH-1:0] resp_rdata [2];

    logic                  in_addr;
    logic                  in_data;
    logic [1:0]            own_addr;
    logic [1:0]            own_data;
    logic [ID_WIDTH-1:0]   grant_id;
    logic                  beat_accept;

    assign req_arvalid   = {m1_arvalid, m0_arvalid};
    assign req_rready    = {m1_rready,  m0_rready};
    assign req_araddr[0] = m0_araddr;
    assign req_araddr[1] = m1_araddr;
    assign req_arlen[0]  = m0_arlen;
    assign req_arlen[1]  = m1_arlen;

    assign in_addr  = (state_q == ST_ADDR);
    assign in_data  = (state_q == ST_DATA);
    assign own_addr = in_addr ? (grant_q ? 2'b10 : 2'b01) : 2'b00;
    assign own_data = in_data ? (grant_q ? 2'b10 : 2'b01) : 2'b00;
    assign grant_id = {{(ID_WIDTH-1){1'b0}}, grant_q};

    // Next-state: arbitration is only ever decided in IDLE, so a grant costs one cycle.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (req_arvalid != 2'b00) begin
                    state_d = ST_ADDR;
                    if (req_arvalid == 2'b11) begin
                        grant_d = ~last_q;
                    end else begin
                        grant_d = req_arvalid[1];
                    end
                end
            end
            ST_ADDR: begin
                if (!req_arvalid[grant_q]) begin
                    state_d = ST_IDLE;
                end else if (axi_arready) begin
                    last_d  = grant_q;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (beat_accept && axi_rlast) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    // Downstream side: address path only live in ADDR, response ready only in DATA.
    assign axi_arvalid = in_addr & req_arvalid[grant_q];
    assign axi_araddr  = in_addr ? req_araddr[grant_q] : '0;
    assign axi_arlen   = in_addr ? req_arlen[grant_q]  : '0;
    assign axi_arid    = in_addr ? grant_id            : '0;
    assign axi_rready  = in_data & req_rready[grant_q];
    assign beat_accept = axi_rvalid & axi_rready;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            assign resp_arready[gi] = own_addr[gi] & axi_arready;
            assign resp_rvalid[gi]  = own_data[gi] & axi_rvalid;
            assign resp_rlast[gi]   = own_data[gi] & axi_rlast;
            assign resp_rdata[gi]   = own_data[gi] ? axi_rdata : '0;
        end
    endgenerate

    assign m0_arready = resp_arready[0];
    assign m0_rvalid  = resp_rvalid[0];
    assign m0_rlast   = resp_rlast[0];
    assign m0_rdata   = resp_rdata[0];
    assign m1_arready = resp_arready[1];
    assign m1_rvalid  = resp_rvalid[1];
    assign m1_rlast   = resp_rlast[1];
    assign m1_rdata   = resp_rdata[1];

`ifdef ARB_ID_CHECK_EN
    logic arb_err_q, arb_err_d;

    // Errant beats are still forwarded; the flag only records that one was seen.
    always_comb begin
        arb_err_d = arb_err_q;
        if (beat_accept && (axi_rid != grant_id)) begin
            arb_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            arb_err_q <= 1'b0;
        end else begin
            arb_err_q <= arb_err_d;
        end
    end

    assign arb_err = arb_err_q;
`else
    logic unused_rid;
    assign unused_rid = ^axi_rid;
`endif

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Directed bench for mem_read_arbiter; inputs change 1 time unit after the rising edge, checks 1 unit later.
// Defining ARB_ID_CHECK_EN also exercises the sticky arb_err output.
module tb_mem_read_arbiter;

    localparam int IDW = 13;
    localparam int AW  = 64;
    localparam int DW  = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic          m0_arvalid, m0_arready, m0_rvalid, m0_rready, m0_rlast;
    logic [AW-1:0] m0_araddr;
    logic [7:0]    m0_arlen;
    logic [DW-1:0] m0_rdata;
    logic          m1_arvalid, m1_arready, m1_rvalid, m1_rready, m1_rlast;
    logic [AW-1:0] m1_araddr;
    logic [7:0]    m1_arlen;
    logic [DW-1:0] m1_rdata;
    logic          axi_arvalid, axi_arready, axi_rvalid, axi_rready, axi_rlast;
    logic [AW-1:0] axi_araddr;
    logic [7:0]    axi_arlen;
    logic [IDW-1:0] axi_arid, axi_rid;
    logic [DW-1:0] axi_rdata;
`ifdef ARB_ID_CHECK_EN
    logic          arb_err;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_read_arbiter #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset),
        .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_araddr(m0_araddr), .m0_arlen(m0_arlen),
        .m0_rvalid(m0_rvalid), .m0_rready(m0_rready), .m0_rdata(m0_rdata), .m0_rlast(m0_rlast),
        .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_araddr(m1_araddr), .m1_arlen(m1_arlen),
        .m1_rvalid(m1_rvalid), .m1_rready(m1_rready), .m1_rdata(m1_rdata), .m1_rlast(m1_rlast),
        .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_araddr(axi_araddr),
        .axi_arlen(axi_arlen), .axi_arid(axi_arid),
        .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .axi_rdata(axi_rdata),
        .axi_rlast(axi_rlast), .axi_rid(axi_rid)
`ifdef ARB_ID_CHECK_EN
        , .arb_err(arb_err)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        reset = 1'b1;
        m0_arvalid = 0; m0_araddr = '0; m0_arlen = '0; m0_rready = 0;
        m1_arvalid = 0; m1_araddr = '0; m1_arlen = '0; m1_rready = 0;
        axi_arready = 0; axi_rvalid = 0; axi_rdata = '0; axi_rlast = 0; axi_rid = '0;
        settle();
        chk("rst_axi_arvalid", axi_arvalid, 0);
        chk("rst_m0_arready", m0_arready, 0);
        chk("rst_m1_arready", m1_arready, 0);
        chk("rst_axi_rready", axi_rready, 0);
        chk("rst_m1_rdata", m1_rdata, 0);
        chk("rst_axi_araddr", axi_araddr, 0);
        step(); step();
        reset = 1'b0;
        step();

        // Single requester m1, 4-beat burst
        m1_arvalid = 1; m1_araddr = 64'h1000; m1_arlen = 8'd3; m1_rready = 1;
        settle();
        chk("t1_idle_axi_arvalid", axi_arvalid, 0);
        chk("t1_idle_m1_arready", m1_arready, 0);
        step();
        settle();
        chk("t1_addr_arvalid", axi_arvalid, 1);
        chk("t1_addr_arid", axi_arid, 1);
        chk("t1_addr_araddr", axi_araddr, 64'h1000);
        chk("t1_addr_arlen", axi_arlen, 3);
        chk("t1_addr_m1_arready_lo", m1_arready, 0);
        axi_arready = 1;
        settle();
        chk("t1_addr_m1_arready_hi", m1_arready, 1);
        chk("t1_addr_m0_arready", m0_arready, 0);
        step();
        m1_arvalid = 0; axi_arready = 0;
        for (int i = 0; i < 4; i++) begin
            axi_rvalid = 1; axi_rdata = 64'hA0 + 64'(i); axi_rlast = (i == 3); axi_rid = 13'd1;
            settle();
            $display("t1 beat %0d: m1_rvalid=%0b m1_rdata=%0h m1_rlast=%0b", i, m1_rvalid, m1_rdata, m1_rlast);
            chk("t1_m1_rvalid", m1_rvalid, 1);
            chk("t1_m1_rdata", m1_rdata, 64'hA0 + 64'(i));
            chk("t1_m1_rlast", m1_rlast, (i == 3) ? 1 : 0);
            chk("t1_m0_rvalid", m0_rvalid, 0);
            chk("t1_m0_rdata", m0_rdata, 0);
            chk("t1_axi_rready", axi_rready, 1);
            step();
        end
        axi_rlast = 0;
        settle();
        chk("t1_stray_axi_rready", axi_rready, 0);
        chk("t1_stray_m1_rvalid", m1_rvalid, 0);
        axi_rvalid = 0;

        // Simultaneous requests right after reset: m0 first
        reset = 1; step(); reset = 0;
        m0_arvalid = 1; m0_araddr = 64'h2000; m0_arlen = 0; m0_rready = 1;
        m1_arvalid = 1; m1_araddr = 64'h3000; m1_arlen = 0;
        axi_arready = 1;
        settle();
        chk("t2_idle_m0_arready", m0_arready, 0);
        chk("t2_idle_m1_arready", m1_arready, 0);
        step();
        settle();
        chk("t2_addr_arid", axi_arid, 0);
        chk("t2_addr_araddr", axi_araddr, 64'h2000);
        chk("t2_addr_m0_arready", m0_arready, 1);
        chk("t2_addr_m1_arready", m1_arready, 0);
        step();
        m0_arvalid = 0;
        axi_rvalid = 1; axi_rlast = 1; axi_rdata = 64'h77;
        settle();
        chk("t2_data_m1_arready", m1_arready, 0);
        chk("t2_data_m0_rvalid", m0_rvalid, 1);
        chk("t2_data_m1_rvalid", m1_rvalid, 0);
        step();
        axi_rvalid = 0; axi_rlast = 0;
        settle();
        chk("t2_idle2_axi_arvalid", axi_arvalid, 0);
        chk("t2_idle2_m1_arready", m1_arready, 0);
        step();
        settle();
        chk("t2_addr2_arid", axi_arid, 1);
        chk("t2_addr2_m1_arready", m1_arready, 1);
        chk("t2_addr2_m0_arready", m0_arready, 0);
        step();
        m1_arvalid = 0;
        axi_rvalid = 1; axi_rlast = 1; axi_rdata = 64'h88;
        settle();
        chk("t2_data2_m1_rvalid", m1_rvalid, 1);
        chk("t2_data2_m1_rdata", m1_rdata, 64'h88);
        step();
        axi_rvalid = 0; axi_rlast = 0;

        // Four back-to-back bursts with both always requesting: 0,1,0,1
        m0_arvalid = 1; m1_arvalid = 1; m1_rready = 1; axi_arready = 1;
        for (int k = 0; k < 4; k++) begin
            step();
            settle();
            $display("t3 burst %0d: axi_arid=%0d", k, axi_arid);
            chk("t3_grant_arid", axi_arid, k % 2);
            step();
            axi_rvalid = 1; axi_rlast = 1; axi_rdata = 64'(k);
            settle();
            chk("t3_owner_rvalid", (k % 2 == 0) ? m0_rvalid : m1_rvalid, 1);
            chk("t3_other_rvalid", (k % 2 == 0) ? m1_rvalid : m0_rvalid, 0);
            step();
            axi_rvalid = 0; axi_rlast = 0;
        end
        m0_arvalid = 0; m1_arvalid = 0;
        step();

        // m0 single beat with a slow downstream address ready
        m0_arvalid = 1; m0_araddr = 64'h4000; m0_arlen = 0; axi_arready = 0;
        step();
        for (int w = 0; w < 5; w++) begin
            settle();
            chk("t4_wait_arvalid", axi_arvalid, 1);
            chk("t4_wait_araddr", axi_araddr, 64'h4000);
            chk("t4_wait_m0_arready", m0_arready, 0);
            step();
        end
        axi_arready = 1;
        settle();
        chk("t4_m0_arready", m0_arready, 1);
        step();
        m0_arvalid = 0; axi_arready = 0;
        axi_rvalid = 1; axi_rlast = 1; axi_rdata = 64'h55;
        settle();
        chk("t4_m0_rdata", m0_rdata, 64'h55);
        chk("t4_m0_rlast", m0_rlast, 1);
        step();
        axi_rvalid = 0; axi_rlast = 0;
        settle();
        chk("t4_idle_axi_rready", axi_rready, 0);

        // Requester withdraws in ADDR: back to IDLE, nothing issued
        m1_arvalid = 1; m1_araddr = 64'h6000;
        step();
        m1_arvalid = 0;
        settle();
        chk("t6_drop_axi_arvalid", axi_arvalid, 0);
        step();
        axi_rvalid = 1;
        settle();
        chk("t6_drop_axi_rready", axi_rready, 0);
        axi_rvalid = 0;

        // Reset during beat 2 of a 4-beat m1 burst
        m1_arvalid = 1; m1_araddr = 64'h1000; m1_arlen = 3; axi_arready = 1;
        step();
        step();
        m1_arvalid = 0; axi_arready = 0;
        axi_rvalid = 1; axi_rlast = 0; axi_rdata = 64'hB0;
        settle();
        chk("t5_beat1_m1_rvalid", m1_rvalid, 1);
        step();
        axi_rdata = 64'hB1; reset = 1;
        settle();
        chk("t5_rst_m1_rvalid", m1_rvalid, 0);
        chk("t5_rst_m1_rdata", m1_rdata, 0);
        chk("t5_rst_axi_rready", axi_rready, 0);
        chk("t5_rst_axi_arvalid", axi_arvalid, 0);
        step();
        reset = 0; axi_rvalid = 0;
        m0_arvalid = 1; m0_araddr = 64'h5000; m0_arlen = 0;
        step();
        settle();
        chk("t5_after_arvalid", axi_arvalid, 1);
        chk("t5_after_arid", axi_arid, 0);
        chk("t5_after_araddr", axi_araddr, 64'h5000);
        axi_arready = 1;
        step();
        m0_arvalid = 0; axi_arready = 0;
        axi_rvalid = 1; axi_rlast = 1;
        settle();
        chk("t5_after_m0_rlast", m0_rlast, 1);
        step();
        axi_rvalid = 0; axi_rlast = 0;

`ifdef ARB_ID_CHECK_EN
        // Wrong rid during an m1 burst raises a sticky error
        m1_arvalid = 1; m1_araddr = 64'h7000; m1_arlen = 1; axi_arready = 1;
        step();
        step();
        m1_arvalid = 0; axi_arready = 0;
        settle();
        chk("t7_err_before", arb_err, 0);
        axi_rvalid = 1; axi_rlast = 0; axi_rid = '0;
        settle();
        chk("t7_err_same_cycle", arb_err, 0);
        chk("t7_beat_forwarded", m1_rvalid, 1);
        step();
        axi_rid = 13'd1; axi_rlast = 1;
        settle();
        chk("t7_err_rise", arb_err, 1);
        step();
        axi_rvalid = 0; axi_rlast = 0;
        step();
        settle();
        chk("t7_err_sticky", arb_err, 1);
        reset = 1;
        settle();
        chk("t7_err_reset", arb_err, 0);
        step();
        reset = 0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
